bit_serial_subtractor: RTL
==========================

BIT_SERIAL_SUBTRACTOR -- requirements
Module: bit_serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  request to subtract; sampled only when ready=1.
REQ-006 a  in  WIDTH  minuend; captured on start acceptance.
REQ-007 b  in  WIDTH  subtrahend; captured on start acceptance.
REQ-008 bin  in  1  borrow-in; captured on start acceptance.
REQ-009 ready  out  1  high only in IDLE.
REQ-010 busy  out  1  high only in RUN.
REQ-011 done  out  1  one-cycle pulse, high only in DONE.
REQ-012 diff  out  WIDTH  registered result, a - b - bin mod 2^WIDTH.
REQ-013 bout  out  1  registered borrow-out of the MSB stage.
REQ-014 v  out  1  registered signed-overflow flag.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 Transitions: IDLE->RUN when start=1; RUN->DONE after WIDTH RUN cycles; DONE->IDLE unconditionally; all other cases hold.
REQ-017 On acceptance, the block SHALL load a and b into right-shift registers, load bin into the borrow flop and clear the bit counter.
REQ-018 Each RUN cycle SHALL process exactly one bit, LSB first.
  - d = a_sr[0]^b_sr[0]^brw
  - bo = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&brw)
  - d shifts into the result shift-register MSB.
  - Both operand registers shift right; brw<=bo; counter increments.
REQ-019 When counter=WIDTH-1 in RUN, the next state SHALL be DONE.
REQ-020 On entry to DONE, diff, bout and v SHALL load together.
  - diff = result shift register; bout = final borrow.
  - v = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the captured operands.
REQ-021 Latency: if start is accepted at edge E0, done SHALL be high for exactly the cycle after edge E0+WIDTH.
REQ-022 diff, bout and v SHALL hold their values from DONE until the next DONE entry; they SHALL NOT change during RUN.
REQ-023 start asserted in RUN or DONE SHALL be ignored; it SHALL NOT queue and SHALL NOT corrupt the operation in progress.
REQ-024 start asserted in the cycle after done SHALL be accepted, giving back-to-back throughput of one result per WIDTH+2 cycles.
REQ-025 Changes on a, b or bin after acceptance SHALL have no effect on the result.
REQ-026 Counter width SHALL be clog2(WIDTH)+1 bits, with no wrap in legal operation.

Reset
REQ-027 rst=1 at an edge SHALL force: state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0, v=0, counter=0, borrow flop=0, shift registers=0.
REQ-028 Reset SHALL take priority over start and over any in-flight operation.
REQ-029 Reset asserted mid-RUN SHALL abandon the operation with no done pulse, and the outputs SHALL read as the reset values.

Structure
REQ-030 Shared package sub_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the default-width constant SUB_WIDTH_DEFAULT=8.
REQ-031 The per-bit datapath SHALL be one instance of the existing 1-bit cell full_subractor (ports a, b, bin, d, bout); there SHALL be no other sub-modules.

Verification (WIDTH=8)
REQ-032 a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, v=0; done exactly 8 edges after the accepting edge, high for 1 cycle.
REQ-033 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, v=0; a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-034 a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, v=1; a=0x7F, b=0xFF, bin=0 -> diff=0x80, v=1.
REQ-035 start held high through RUN while a and b change -> single result from the captured operands; the restart in the cycle after done is accepted.
REQ-036 rst pulsed at the 4th RUN cycle -> next cycle ready=1, diff=0, bout=0, v=0, and done never pulses.
REQ-037 Random soak of 1000 operations -> every result matches the a-b-bin reference model, and done count equals accepted-start count.

Source files
------------

// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and constants for the bit-serial subtractor
//
// Purpose: holds the sequencer state type and the default operand width.
// Ports:   none (package).

package sub_pkg;

  localparam int SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage : sub_pkg

// File: rtl/full_subractor.sv
// rtl/full_subractor.sv - 1-bit full subtractor cell
//
// Purpose: single-bit a - b - bin with borrow out.
// Ports:
//   a    in   minuend bit
//   b    in   subtrahend bit
//   bin  in   borrow in
//   d    out  difference bit
//   bout out  borrow out

module full_subractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subractor

// File: rtl/bit_serial_subtractor.sv
// rtl/bit_serial_subtractor.sv - LSB-first bit-serial a - b - bin
//
// Purpose: accepts one subtraction in IDLE, processes one bit per RUN cycle
//          through a single full_subractor cell, and publishes diff/bout/v
//          on entry to DONE (one-cycle done pulse).
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only while ready=1
//   a      in   [WIDTH] minuend, captured on acceptance
//   b      in   [WIDTH] subtrahend, captured on acceptance
//   bin    in   borrow in, captured on acceptance
//   ready  out  high in IDLE
//   busy   out  high in RUN
//   done   out  high in DONE (one cycle)
//   diff   out  [WIDTH] registered a - b - bin mod 2^WIDTH
//   bout   out  registered borrow out of the MSB stage
//   v      out  registered signed-overflow flag

module bit_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             v
);

  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  sub_state_t       r_state;
  sub_state_t       w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  // Operand sign bits are kept aside because the shift registers lose them.
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_v;

  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  full_subractor u_cell (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_brw),
    .d    (w_d),
    .bout (w_bo)
  );

  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_res_next = {w_d, r_res_sr[WIDTH-1:1]};

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_brw    <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_brw   <= bin;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
          end
        end
        RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= w_res_next;
          r_brw    <= w_bo;
          r_cnt    <= r_cnt + CNT_W'(1);
          // The last bit goes straight into the published result so that
          // diff/bout/v change together on the edge that enters DONE.
          if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_bo;
            r_v    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign v    = r_v;

endmodule : bit_serial_subtractor
